// File: rtl/id_decode_unit_if.sv
// Decode-stage bus: instruction/writeback in, register reads, decode flags and target out.
interface id_decode_unit_if;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic [31:0] Instr_PC_Plus4;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Write1;
  logic [31:0] DataA1, DataB1, DataC1;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite;
  logic        ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;
  logic [31:0] NextInstructionAddress;

  modport master (
    output Instr, Instr_PC, Instr_PC_Plus4, WriteReg1, WriteData1, Write1,
    input  DataA1, DataB1, DataC1, Link, RegDest, Jump, Branch, MemRead, MemWrite,
           ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall, ALUControl,
           NextInstructionAddress
  );

  modport slave (
    input  Instr, Instr_PC, Instr_PC_Plus4, WriteReg1, WriteData1, Write1,
    output DataA1, DataB1, DataC1, Link, RegDest, Jump, Branch, MemRead, MemWrite,
           ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall, ALUControl,
           NextInstructionAddress
  );
endinterface

// File: rtl/id_decode_unit.sv
// MIPS ID core: 32x32 register file with write bypass, full instruction decode,
// and branch/jump target generation.
module id_decode_unit #(
  parameter TAG = "1"
) (
  input logic CLK,
  input logic RESET,
  id_decode_unit_if.slave io
);

  typedef struct packed {
    logic       link, reg_dest, jump, branch, mem_read, mem_write;
    logic       alu_src, reg_write, jump_reg, sign_ext, syscall;
    logic [5:0] alu;
  } dec_t;

  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] data_a, data_b, data_c;
  dec_t        d;

  assign op    = io.Instr[31:26];
  assign rs    = io.Instr[25:21];
  assign rt    = io.Instr[20:16];
  assign rd    = io.Instr[15:11];
  assign funct = io.Instr[5:0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (io.Write1 && io.WriteReg1 != 5'd0) begin
      regs[io.WriteReg1] <= io.WriteData1;
    end
  end

  // Writeback in the same cycle wins over the stored value.
  logic wr_live;
  assign wr_live = io.Write1 && (io.WriteReg1 != 5'd0);

  assign data_a = (rs == 5'd0) ? '0 : (wr_live && io.WriteReg1 == rs) ? io.WriteData1 : regs[rs];
  assign data_b = (rt == 5'd0) ? '0 : (wr_live && io.WriteReg1 == rt) ? io.WriteData1 : regs[rt];
  assign data_c = (dest == 5'd0) ? '0 : (wr_live && io.WriteReg1 == dest) ? io.WriteData1 : regs[dest];

  always_comb begin
    d = '0;
    d.alu = 6'b000001;
    case (op)
      6'h00: case (funct)
        // Most R-type ALU codes coincide with the funct field.
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h22,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
          d.reg_dest = 1'b1; d.reg_write = 1'b1; d.alu = funct;
        end
        6'h21: begin d.reg_dest = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100000; end
        6'h23: begin d.reg_dest = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100010; end
        6'h08: begin d.reg_dest = 1'b1; d.jump = 1'b1; d.jump_reg = 1'b1; end
        6'h09: begin
          d.reg_dest = 1'b1; d.jump = 1'b1; d.jump_reg = 1'b1; d.branch = 1'b1;
          d.link = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100000;
        end
        6'h0C: begin d.reg_dest = 1'b1; d.syscall = 1'b1; d.alu = 6'b001100; end
        default: ;
      endcase
      6'h01: case (rt)
        5'h00, 5'h01: begin d.branch = 1'b1; d.sign_ext = 1'b1; end
        5'h10, 5'h11: begin
          d.branch = 1'b1; d.sign_ext = 1'b1; d.link = 1'b1;
          d.reg_write = 1'b1; d.alu = 6'b100000;
        end
        default: ;
      endcase
      6'h02: d.jump = 1'b1;
      6'h03: begin
        d.jump = 1'b1; d.branch = 1'b1; d.link = 1'b1;
        d.reg_write = 1'b1; d.alu = 6'b100000;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin d.branch = 1'b1; d.sign_ext = 1'b1; end
      6'h08, 6'h09: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1; d.alu = 6'b100000; end
      6'h0A: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1; d.alu = 6'b101010; end
      6'h0B: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1; d.alu = 6'b101011; end
      6'h0C: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100100; end
      6'h0D: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100101; end
      6'h0E: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu = 6'b100110; end
      6'h0F: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu = 6'b001111; end
      // Load/store codes are 11 followed by the low opcode nibble.
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d.mem_read = 1'b1; d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1;
        d.alu = {2'b11, op[3:0]};
      end
      6'h28, 6'h29, 6'h2B: begin
        d.mem_write = 1'b1; d.alu_src = 1'b1; d.sign_ext = 1'b1;
        d.alu = {2'b11, op[3:0]};
      end
      6'h30: begin
        d.mem_read = 1'b1; d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1;
        d.syscall = 1'b1; d.alu = 6'b101000;
      end
      6'h38: begin
        d.mem_write = 1'b1; d.alu_src = 1'b1; d.reg_write = 1'b1; d.sign_ext = 1'b1;
        d.syscall = 1'b1; d.alu = 6'b110110;
      end
      default: ;
    endcase
  end

  assign dest = d.reg_dest ? rd : (d.link ? 5'd31 : rt);

  assign io.DataA1       = data_a;
  assign io.DataB1       = data_b;
  assign io.DataC1       = data_c;
  assign io.Link         = d.link;
  assign io.RegDest      = d.reg_dest;
  assign io.Jump         = d.jump;
  assign io.Branch       = d.branch;
  assign io.MemRead      = d.mem_read;
  assign io.MemWrite     = d.mem_write;
  assign io.ALUSrc       = d.alu_src;
  assign io.RegWrite     = d.reg_write;
  assign io.JumpRegister = d.jump_reg;
  assign io.SignOrZero   = d.sign_ext;
  assign io.Syscall      = d.syscall;
  assign io.ALUControl   = d.alu;

  logic [31:0] br_off;
  assign br_off = {{14{io.Instr[15]}}, io.Instr[15:0], 2'b00};

  assign io.NextInstructionAddress =
    (d.jump && d.jump_reg) ? data_a :
    d.jump                 ? {io.Instr_PC_Plus4[31:28], io.Instr[25:0], 2'b00} :
                             io.Instr_PC_Plus4 + br_off;

  // PC and tag only feed simulation-side debug output.
  logic unused_dbg;
  assign unused_dbg = ^{io.Instr_PC, TAG};

endmodule

// File: tb/tb_id_decode_unit.sv
// Directed bench for id_decode_unit: register file, bypass, decode flags and targets.
module tb_id_decode_unit;
  logic CLK = 1'b0;
  logic RESET;
  int n_cmp = 0;
  int n_err = 0;

  id_decode_unit_if bus();
  id_decode_unit #(.TAG("TB")) dut (.CLK(CLK), .RESET(RESET), .io(bus));

  always #5 CLK = ~CLK;

  // L RD J B MR MW AS RW JR SZ SC
  logic [10:0] flags;
  assign flags = {bus.Link, bus.RegDest, bus.Jump, bus.Branch, bus.MemRead, bus.MemWrite,
                  bus.ALUSrc, bus.RegWrite, bus.JumpRegister, bus.SignOrZero, bus.Syscall};

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    bus.Write1 = 1'b1; bus.WriteReg1 = r; bus.WriteData1 = v;
    @(posedge CLK); #1;
    bus.Write1 = 1'b0;
  endtask

  task automatic test_reset;
    wr(5'd7, 32'hDEADBEEF);
    bus.Instr = {6'h00, 5'd7, 21'h0}; #1;
    n_cmp++; if (bus.DataA1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_r7 got %h exp %h", bus.DataA1, 32'hDEADBEEF); end
    RESET = 1'b0; #1;
    n_cmp++; if (bus.DataA1 !== 32'h0) begin n_err++; $display("FAIL async_clear_r7 got %h exp 0", bus.DataA1); end
    for (int i = 1; i < 32; i++) begin
      bus.Instr = {6'h00, 5'(i), 21'h0}; #1;
      n_cmp++; if (bus.DataA1 !== 32'h0) begin n_err++; $display("FAIL reset_r%0d got %h exp 0", i, bus.DataA1); end
    end
    RESET = 1'b1;
    @(negedge CLK);
    bus.Instr = 32'h0; bus.Write1 = 1'b1; bus.WriteReg1 = 5'd0; bus.WriteData1 = 32'hFFFFFFFF; #1;
    n_cmp++; if (bus.DataA1 !== 32'h0) begin n_err++; $display("FAIL r0_no_bypass got %h exp 0", bus.DataA1); end
    @(posedge CLK); #1; bus.Write1 = 1'b0; #1;
    n_cmp++; if (bus.DataA1 !== 32'h0) begin n_err++; $display("FAIL r0_after_write got %h exp 0", bus.DataA1); end
  endtask

  task automatic test_addu_bypass;
    wr(5'd5, 32'h12345678);
    bus.Instr = 32'h00A61821; #1;
    n_cmp++; if (bus.DataA1 !== 32'h12345678) begin n_err++; $display("FAIL addu_rs got %h exp %h", bus.DataA1, 32'h12345678); end
    n_cmp++; if (flags !== 11'b01000001000) begin n_err++; $display("FAIL addu_flags got %b exp %b", flags, 11'b01000001000); end
    n_cmp++; if (bus.ALUControl !== 6'b100000) begin n_err++; $display("FAIL addu_alu got %b exp %b", bus.ALUControl, 6'b100000); end
    n_cmp++; if (bus.DataB1 !== 32'h0) begin n_err++; $display("FAIL addu_rt_pre got %h exp 0", bus.DataB1); end
    bus.Write1 = 1'b1; bus.WriteReg1 = 5'd6; bus.WriteData1 = 32'd7; #1;
    n_cmp++; if (bus.DataB1 !== 32'd7) begin n_err++; $display("FAIL addu_rt_bypass got %h exp 7", bus.DataB1); end
    @(posedge CLK); #1; bus.Write1 = 1'b0; #1;
    n_cmp++; if (bus.DataB1 !== 32'd7) begin n_err++; $display("FAIL addu_rt_stored got %h exp 7", bus.DataB1); end
    bus.Write1 = 1'b1; bus.WriteReg1 = 5'd3; bus.WriteData1 = 32'hCAFEF00D; #1;
    n_cmp++; if (bus.DataC1 !== 32'hCAFEF00D) begin n_err++; $display("FAIL addu_rd_bypass got %h exp %h", bus.DataC1, 32'hCAFEF00D); end
    bus.Write1 = 1'b0;
  endtask

  task automatic test_branch;
    bus.Instr = 32'h1000FFFF; bus.Instr_PC_Plus4 = 32'h00400010; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h0040000C) begin n_err++; $display("FAIL beq_back got %h exp %h", bus.NextInstructionAddress, 32'h0040000C); end
    n_cmp++; if (flags !== 11'b00010000010) begin n_err++; $display("FAIL beq_flags got %b exp %b", flags, 11'b00010000010); end
    n_cmp++; if (bus.ALUControl !== 6'b000001) begin n_err++; $display("FAIL beq_alu got %b exp 000001", bus.ALUControl); end
    bus.Instr = 32'h10000004; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00400020) begin n_err++; $display("FAIL beq_fwd got %h exp %h", bus.NextInstructionAddress, 32'h00400020); end
    bus.Instr = 32'h10000002; bus.Instr_PC_Plus4 = 32'hFFFFFFFC; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00000004) begin n_err++; $display("FAIL beq_wrap got %h exp 4", bus.NextInstructionAddress); end
    bus.Instr = 32'h0530FFFF; bus.Instr_PC_Plus4 = 32'h00400010; #1;
    n_cmp++; if (flags !== 11'b10010001010) begin n_err++; $display("FAIL bltzal_flags got %b exp %b", flags, 11'b10010001010); end
    n_cmp++; if (bus.ALUControl !== 6'b100000) begin n_err++; $display("FAIL bltzal_alu got %b exp 100000", bus.ALUControl); end
  endtask

  task automatic test_jump;
    bus.Instr = 32'h08100000; bus.Instr_PC_Plus4 = 32'h00400004; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00400000) begin n_err++; $display("FAIL j_target got %h exp %h", bus.NextInstructionAddress, 32'h00400000); end
    n_cmp++; if (flags !== 11'b00100000000) begin n_err++; $display("FAIL j_flags got %b exp %b", flags, 11'b00100000000); end
    bus.Instr_PC_Plus4 = 32'hA0000004; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'hA0400000) begin n_err++; $display("FAIL j_region got %h exp %h", bus.NextInstructionAddress, 32'hA0400000); end
    wr(5'd31, 32'h00400100);
    bus.Instr = 32'h03E00008; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00400100) begin n_err++; $display("FAIL jr_target got %h exp %h", bus.NextInstructionAddress, 32'h00400100); end
    n_cmp++; if (flags !== 11'b01100000100) begin n_err++; $display("FAIL jr_flags got %b exp %b", flags, 11'b01100000100); end
    bus.Write1 = 1'b1; bus.WriteReg1 = 5'd31; bus.WriteData1 = 32'h00400200; #1;
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00400200) begin n_err++; $display("FAIL jr_bypass got %h exp %h", bus.NextInstructionAddress, 32'h00400200); end
    bus.Write1 = 1'b0; #1;
  endtask

  task automatic test_jal;
    bus.Instr = 32'h0C100000; bus.Instr_PC_Plus4 = 32'h00400004; #1;
    n_cmp++; if (flags !== 11'b10110001000) begin n_err++; $display("FAIL jal_flags got %b exp %b", flags, 11'b10110001000); end
    n_cmp++; if (bus.ALUControl !== 6'b100000) begin n_err++; $display("FAIL jal_alu got %b exp 100000", bus.ALUControl); end
    n_cmp++; if (bus.DataC1 !== 32'h00400100) begin n_err++; $display("FAIL jal_dest_r31 got %h exp %h", bus.DataC1, 32'h00400100); end
    n_cmp++; if (bus.NextInstructionAddress !== 32'h00400000) begin n_err++; $display("FAIL jal_target got %h exp %h", bus.NextInstructionAddress, 32'h00400000); end
  endtask

  task automatic test_special;
    bus.Instr = 32'h0000000C; #1;
    n_cmp++; if (flags !== 11'b01000000001) begin n_err++; $display("FAIL syscall_flags got %b exp %b", flags, 11'b01000000001); end
    n_cmp++; if (bus.ALUControl !== 6'b001100) begin n_err++; $display("FAIL syscall_alu got %b exp 001100", bus.ALUControl); end
    bus.Instr = 32'hC0A20000; #1;
    n_cmp++; if (flags !== 11'b00001011011) begin n_err++; $display("FAIL ll_flags got %b exp %b", flags, 11'b00001011011); end
    n_cmp++; if (bus.ALUControl !== 6'b101000) begin n_err++; $display("FAIL ll_alu got %b exp 101000", bus.ALUControl); end
    bus.Instr = 32'hE0A20000; #1;
    n_cmp++; if (flags !== 11'b00000111011) begin n_err++; $display("FAIL sc_flags got %b exp %b", flags, 11'b00000111011); end
    n_cmp++; if (bus.ALUControl !== 6'b110110) begin n_err++; $display("FAIL sc_alu got %b exp 110110", bus.ALUControl); end
    bus.Instr = 32'h34A200FF; #1;
    n_cmp++; if (flags !== 11'b00000011000) begin n_err++; $display("FAIL ori_flags got %b exp %b", flags, 11'b00000011000); end
    n_cmp++; if (bus.ALUControl !== 6'b100101) begin n_err++; $display("FAIL ori_alu got %b exp 100101", bus.ALUControl); end
  endtask

  task automatic test_mem_misc;
    bus.Instr = 32'h8CA20004; #1;
    n_cmp++; if (flags !== 11'b00001011010) begin n_err++; $display("FAIL lw_flags got %b exp %b", flags, 11'b00001011010); end
    n_cmp++; if (bus.ALUControl !== 6'b110011) begin n_err++; $display("FAIL lw_alu got %b exp 110011", bus.ALUControl); end
    bus.Instr = 32'hACA20004; #1;
    n_cmp++; if (flags !== 11'b00000110010) begin n_err++; $display("FAIL sw_flags got %b exp %b", flags, 11'b00000110010); end
    n_cmp++; if (bus.ALUControl !== 6'b111011) begin n_err++; $display("FAIL sw_alu got %b exp 111011", bus.ALUControl); end
    bus.Instr = 32'hFC000000; #1;
    n_cmp++; if (flags !== 11'b0 || bus.ALUControl !== 6'b000001) begin n_err++; $display("FAIL bad_op got %b/%b exp 0/000001", flags, bus.ALUControl); end
    bus.Instr = 32'h0000003F; #1;
    n_cmp++; if (flags !== 11'b0 || bus.ALUControl !== 6'b000001) begin n_err++; $display("FAIL bad_funct got %b/%b exp 0/000001", flags, bus.ALUControl); end
    bus.Instr = 32'h00000000; #1;
    n_cmp++; if (flags !== 11'b01000001000 || bus.ALUControl !== 6'b000000) begin n_err++; $display("FAIL nop got %b/%b exp 01000001000/000000", flags, bus.ALUControl); end
    bus.Instr = 32'h00A61803; #1;
    n_cmp++; if (bus.ALUControl !== 6'b000011) begin n_err++; $display("FAIL sra_alu got %b exp 000011", bus.ALUControl); end
  endtask

  initial begin
    RESET = 1'b0;
    bus.Instr = '0; bus.Instr_PC = 32'h00400000; bus.Instr_PC_Plus4 = '0;
    bus.WriteReg1 = '0; bus.WriteData1 = '0; bus.Write1 = 1'b0;
    #12 RESET = 1'b1;
    @(negedge CLK);
    test_reset;
    test_addu_bypass;
    test_branch;
    test_jump;
    test_jal;
    test_special;
    test_mem_misc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
